punc_mem_responder: RTL

//  Memory-side responder for the PUnC LC3 core: serves the fetch, load and store requests the control unit issues.

---
 rtl/punc_mem_responder.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/punc_mem_responder.sv
// ============================================================================
// punc_mem_responder
// ----------------------------------------------------------------------------
// Memory-side responder for the PUnC LC3 core. It serves the fetch, load and
// store requests issued by the control unit out of a word-addressed
// single-port RAM. Read and write latencies are programmable so that the
// control FSM can be exercised against multi-cycle memory. Only one
// transaction is in flight at a time.
//
// Handshakes (both channels): a transfer happens on every rising clk edge
// where valid & ready are both high. valid never waits on ready. Once the
// responder raises rsp_valid, rsp_valid/rsp_rdata/rsp_err hold until the
// edge where rsp_ready is sampled high. req_ready depends on state only and
// never on req_valid.
//
// Parameters
//   DEPTH       words of storage, power of 2, 2..65536
//   RD_LATENCY  wait cycles before a read is performed   (0..7)
//   WR_LATENCY  wait cycles before a write is committed  (0..7)
//
// Compile-time option
//   PUNC_MEM_ERR_EN  when defined, requests with req_addr >= DEPTH perform no
//                    access and respond with rsp_err=1, rsp_rdata=0. When
//                    undefined, the address wraps modulo DEPTH and rsp_err
//                    is tied low.
//
// Ports
//   clk        in   1   clock
//   rst        in   1   synchronous, active-high reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept a request (state == IDLE)
//   req_we     in   1   1 = write, 0 = read
//   req_addr   in   16  word address
//   req_wdata  in   16  write data
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   initiator accepts the response
//   rsp_rdata  out  16  read data; for a write, the data that was written
//   rsp_err    out  1   address out of range (PUNC_MEM_ERR_EN only)
//   busy       out  1   a transaction is accepted and not yet consumed
//   dbg_addr   in   16  debug peek address (combinational)
//   dbg_rdata  out  16  mem[dbg_addr mod DEPTH]
//   dbg_state  out  2   current FSM state (0 IDLE, 1 WAIT, 2 RESP)
// ============================================================================
module punc_mem_responder #(
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    input  logic [15:0] dbg_addr,
    output logic [15:0] dbg_rdata,
    output logic [1:0]  dbg_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Latched request and wait counter.
    logic          we_q;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [2:0]    cnt;

    // Response register.
    logic [15:0]   rdata_q;

    // Backing store; intentionally not cleared by reset.
    logic [15:0]   mem [DEPTH];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic          accept;
    logic [2:0]    lat_sel;
    logic          access;
    logic          acc_we;
    logic [15:0]   acc_addr;
    logic [15:0]   acc_wdata;
    logic [AW-1:0] acc_idx;
    logic          acc_err;

    assign accept  = (state == ST_IDLE) && req_valid;
    assign lat_sel = req_we ? 3'(WR_LATENCY) : 3'(RD_LATENCY);

    // The access happens on the edge that moves the FSM into RESP: either
    // straight from IDLE for a zero-latency request, or from the last WAIT
    // cycle. A zero-latency access has to use the live request inputs since
    // nothing has been latched yet.
    assign access = (accept && (lat_sel == 3'd0)) ||
                    ((state == ST_WAIT) && (cnt <= 3'd1));

    assign acc_we    = (state == ST_IDLE) ? req_we    : we_q;
    assign acc_addr  = (state == ST_IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state == ST_IDLE) ? req_wdata : wdata_q;
    assign acc_idx   = acc_addr[AW-1:0];

`ifdef PUNC_MEM_ERR_EN
    // 17-bit compare so that DEPTH = 65536 never flags an error.
    assign acc_err = ({1'b0, acc_addr} >= 17'(DEPTH));
`else
    assign acc_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = (lat_sel == 3'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // cnt == 0 cannot be reached in WAIT; treating it like 1
                // guarantees the FSM can never stall here.
                if (cnt <= 3'd1) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, wait counter and response data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            cnt     <= 3'd0;
            rdata_q <= 16'h0000;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= lat_sel;
            end else if ((state == ST_WAIT) && (cnt != 3'd0)) begin
                cnt <= cnt - 3'd1;
            end

            if (access) begin
                if (acc_err) begin
                    rdata_q <= 16'h0000;
                end else if (acc_we) begin
                    rdata_q <= acc_wdata;
                end else begin
                    rdata_q <= mem[acc_idx];
                end
            end
        end
    end

    // Memory write port. Gated by rst so a reset landing on the access edge
    // abandons the write instead of committing it.
    always_ff @(posedge clk) begin
        if (!rst && access && acc_we && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

`ifdef PUNC_MEM_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (access) begin
            err_q <= acc_err;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);
    assign rsp_rdata = rdata_q;
    assign dbg_rdata = mem[dbg_addr[AW-1:0]];
    assign dbg_state = state;

    // Upper address bits are only meaningful for the range check.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dbg_addr, acc_addr};

endmodule
